bcd_to_bin: RTL and testbench



---
 rtl/bcd_to_bin.sv | 122 ++++++++++++
 tb/tb_bcd_to_bin.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/bcd_to_bin.sv
// Sequential four-digit BCD to 14-bit binary converter (reverse double dabble, 14 steps).
// Optional digit validation is enabled by defining BCD2BIN_ERRCHK_EN.
module bcd_to_bin (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [3:0]  thousands,
  input  logic [3:0]  hundreds,
  input  logic [3:0]  tens,
  input  logic [3:0]  ones,
  output logic [13:0] number,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    FIN
  } state_t;

  localparam logic [3:0] LAST_STEP = 4'd13;

  state_t      state, state_next;
  logic [29:0] work, work_next;
  logic [3:0]  step, step_next;
  logic [13:0] number_next;
  logic        busy_next, done_next, err_next;
  logic [29:0] stepped;
  logic        digit_bad;

  // One reverse-dabble step: shift {bcd, bin} right, then pull every BCD field >= 8 back by 3.
  function automatic logic [29:0] dabble_step(input logic [29:0] w);
    logic [29:0] s;
    s = w >> 1;
    for (int i = 0; i < 4; i++) begin
      if (s[14 + 4*i +: 4] >= 4'd8) begin
        s[14 + 4*i +: 4] = s[14 + 4*i +: 4] - 4'd3;
      end
    end
    return s;
  endfunction

  assign stepped = dabble_step(work);

`ifdef BCD2BIN_ERRCHK_EN
  assign digit_bad = (thousands > 4'd9) || (hundreds > 4'd9) ||
                     (tens > 4'd9) || (ones > 4'd9);
`else
  assign digit_bad = 1'b0;
`endif

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_next  = state;
    work_next   = work;
    step_next   = step;
    number_next = number;
    busy_next   = busy;
    done_next   = 1'b0;
    err_next    = err;

    case (state)
      // FIN is also the first idle cycle, so a held start restarts every 15 clocks.
      IDLE, FIN: begin
        state_next = IDLE;
        if (start) begin
          if (digit_bad) begin
            state_next  = FIN;
            number_next = 14'd0;
            err_next    = 1'b1;
            done_next   = 1'b1;
            busy_next   = 1'b0;
          end else begin
            state_next = CONV;
            work_next  = {thousands, hundreds, tens, ones, 14'd0};
            step_next  = 4'd0;
            busy_next  = 1'b1;
          end
        end
      end

      CONV: begin
        work_next = stepped;
        step_next = step + 4'd1;
        if (step == LAST_STEP) begin
          state_next  = FIN;
          number_next = stepped[13:0];
          err_next    = 1'b0;
          done_next   = 1'b1;
          busy_next   = 1'b0;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments; outputs are loaded from the
  // next-state logic so done/number/busy/err all come straight from flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      work   <= '0;
      step   <= '0;
      number <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      state  <= state_next;
      work   <= work_next;
      step   <= step_next;
      number <= number_next;
      busy   <= busy_next;
      done   <= done_next;
      err    <= err_next;
    end
  end

endmodule

// File: tb/tb_bcd_to_bin.sv
// Self-checking bench for bcd_to_bin: vector table, random digits, handshake corners, sampled sweep.
// Define BCD2BIN_ERRCHK_EN for both bench and RTL to exercise digit rejection.
module tb_bcd_to_bin;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [3:0]  thousands, hundreds, tens, ones;
  logic [13:0] number;
  logic        busy, done, err;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  bcd_to_bin dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .thousands (thousands),
    .hundreds  (hundreds),
    .tens      (tens),
    .ones      (ones),
    .number    (number),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [3:0] th, h, t, o;
    int         exp;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: the binary value is just the weighted digit sum.
  function automatic int model(input int th, input int h, input int t, input int o);
    return th * 1000 + h * 100 + t * 10 + o;
  endfunction

  task automatic set_digits(input int v);
    thousands = 4'((v / 1000) % 10);
    hundreds  = 4'((v / 100) % 10);
    tens      = 4'((v / 10) % 10);
    ones      = 4'(v % 10);
  endtask

  // Start one conversion, scramble the digits afterwards, and check latency, busy and result.
  task automatic run_conv(input logic [3:0] th, input logic [3:0] h, input logic [3:0] t,
                          input logic [3:0] o, input int exp, input string name);
    int n;
    bit busy_ok;
    @(negedge clk);
    thousands = th; hundreds = h; tens = t; ones = o;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    set_digits($urandom_range(0, 9999));
    n = 0;
    busy_ok = 1'b1;
    while (!done && n < 30) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      @(negedge clk);
      n++;
    end
    check({name, " latency"}, n, 14);
    check({name, " busy during conv"}, busy_ok, 1);
    check({name, " done"}, done, 1);
    check({name, " number"}, number, exp);
    check({name, " err"}, err, 0);
    check({name, " busy at done"}, busy, 0);
    @(negedge clk);
    check({name, " done single pulse"}, done, 0);
  endtask

  initial begin
    int q[$];
    int n, dones, last_cyc;
    logic [13:0] seen;

    vecs[0] = '{4'd9, 4'd9, 4'd9, 4'd9, 9999};
    vecs[1] = '{4'd0, 4'd0, 4'd0, 4'd0, 0};
    vecs[2] = '{4'd1, 4'd2, 4'd3, 4'd4, 1234};
    vecs[3] = '{4'd0, 4'd0, 4'd0, 4'd7, 7};
    vecs[4] = '{4'd5, 4'd0, 4'd1, 4'd0, 5010};
    vecs[5] = '{4'd8, 4'd0, 4'd9, 4'd1, 8091};
    vecs[6] = '{4'd0, 4'd0, 4'd1, 4'd0, 10};
    vecs[7] = '{4'd8, 4'd1, 4'd9, 4'd2, 8192};

    rst_n = 1'b0; start = 1'b0;
    set_digits(0);
    #23;
    check("reset number", number, 0);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset err", err, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++)
      run_conv(vecs[i].th, vecs[i].h, vecs[i].t, vecs[i].o, vecs[i].exp, $sformatf("vec%0d", i));

    for (int i = 0; i < 20; i++) begin
      int a, b, c, d;
      a = $urandom_range(0, 9); b = $urandom_range(0, 9);
      c = $urandom_range(0, 9); d = $urandom_range(0, 9);
      run_conv(4'(a), 4'(b), 4'(c), 4'(d), model(a, b, c, d), $sformatf("rand%0d", i));
    end

    // start pulsed again mid-conversion must be ignored.
    @(negedge clk);
    set_digits(1234); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    set_digits(5555); start = 1'b1;
    @(negedge clk);
    start = 1'b0; set_digits(1234);
    dones = 0; seen = '0;
    for (int i = 0; i < 30; i++) begin
      if (done) begin dones++; seen = number; end
      @(negedge clk);
    end
    check("restart ignored done count", dones, 1);
    check("restart ignored number", seen, 1234);

    // Reset in the middle of a conversion.
    @(negedge clk);
    set_digits(1234); start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midreset number", number, 0);
    check("midreset busy", busy, 0);
    check("midreset done", done, 0);
    check("midreset err", err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 25; i++) begin
      if (done || busy) dones++;
      @(negedge clk);
    end
    check("midreset discarded", dones, 0);
    run_conv(4'd0, 4'd4, 4'd2, 4'd0, 420, "after reset");

`ifdef BCD2BIN_ERRCHK_EN
    @(negedge clk);
    thousands = 4'd0; hundreds = 4'hA; tens = 4'd0; ones = 4'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("bad digit done", done, 1);
    check("bad digit err", err, 1);
    check("bad digit number", number, 0);
    check("bad digit busy", busy, 0);
    dones = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (busy || done) dones++;
    end
    check("bad digit quiet after", dones, 0);
    run_conv(4'd0, 4'd0, 4'd1, 4'd0, 10, "valid after bad");
`endif

    // Sampled sweep with start held high: back-to-back conversions every 15 clocks.
    for (int v = 0; v < 10000; v += 7) q.push_back(v);
    q.push_back(9999);
    @(negedge clk);
    set_digits(q[0]); start = 1'b1;
    last_cyc = 0;
    for (int i = 0; i < q.size(); i++) begin
      n = 0;
      while (!done && n < 40) begin
        @(negedge clk);
        n++;
      end
      if (!done) begin
        check($sformatf("sweep %0d timeout", q[i]), done, 1);
        break;
      end
      check($sformatf("sweep %0d number", q[i]), number, q[i]);
      if (i > 0) check($sformatf("sweep %0d interval", q[i]), cyc - last_cyc, 15);
      last_cyc = cyc;
      if (i + 1 < q.size()) set_digits(q[i + 1]);
      else start = 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
    repeat (20) @(negedge clk);
    check("sweep idle at end", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
